led_frame_scheduler: RTL and testbench
======================================

Name: led_frame_scheduler

Overview:
- Sequences the GRB serial shipper and shares it between three frame requesters: manual Go (index 0), auto colour-cycle (1) and game tick (2).
- Latches each request with its 12-bit GRB colour, grants one requester round-robin, and drives the ship/Done/allDone handshake.
- Enforces a minimum inter-frame gap and returns a one-cycle acknowledge to the granted requester.
- A watchdog aborts a frame if the shipper stalls.

Parameters:
- NREQ, 3, number of requesters (fixed at 3 for this release).
- GAP_CYC, 1000, idle clk cycles enforced after allDone before the next grant.
- WDOG_CYC, 2000000, maximum clk cycles allowed in SHIP+RET before abort.
- CW, 12, colour width per requester.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  3  per-requester request pulse or level; a rising edge is sampled.
- req_grb  in  36  colours; bits [12i+11:12i] belong to requester i.
- Done  in  1  shipper has sent all data bits.
- allDone  in  1  shipper has sent the reset code.
- shipGRB  out  1  high while data bits must be shipped.
- frame_grb  out  12  colour latched for the current frame.
- grant  out  3  one-hot; the current owner; zero when idle.
- ack  out  3  one-cycle pulse to the owner on frame completion.
- busy  out  1  high in any state other than IDLE.
- wdog_err  out  1  sticky; set on watchdog abort.
- frames  out  16  completed-frame counter; wraps at 0xFFFF to 0.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state IDLE;
  - pending=0, req_q=0;
  - shipGRB=0, frame_grb=0, grant=0, ack=0, busy=0, wdog_err=0, frames=0;
  - rr pointer = 0;
  - gap and watchdog counters = 0.
- Request capture:
  - req_q registers req each cycle.
  - A rising edge (req & ~req_q) sets pending[i] and latches req_grb slice i into col[i].
  - A new edge on an already pending requester overwrites col[i]; only one frame is still owed.
- States: IDLE, ARB, SHIP, RET, GAP.
- IDLE: if any pending bit is set, go to ARB on the next cycle.
- ARB (1 cycle):
  - Grant the first pending index searching from rr upward, wrapping modulo 3.
  - Set grant one-hot, load frame_grb=col[g], clear pending[g], set rr=(g+1) mod 3.
  - Go to SHIP.
  - A capture edge for index g in the ARB cycle itself re-sets pending[g]; set wins over clear.
- SHIP:
  - shipGRB=1.
  - On Done=1, go to RET; shipGRB is 0 in RET.
- RET: on allDone=1, go to GAP.
  - On that transition: ack[g]=1 for exactly one cycle and frames+1.
- GAP:
  - Count GAP_CYC cycles, then go to IDLE and clear grant.
  - Pending requests wait and are not granted during GAP.
- Latencies:
  - Req edge (IDLE, no contention): shipGRB rises on the 3rd clk edge after req rises (req_q capture, ARB, SHIP).
  - Back-to-back frames: shipGRB rises at least GAP_CYC+2 cycles after allDone.
- Watchdog:
  - The counter runs in SHIP and RET and clears on entry to SHIP.
  - Reaching WDOG_CYC from SHIP or RET goes to GAP with shipGRB=0.
  - Abort sets wdog_err; no ack and no frames increment.
  - wdog_err clears only on reset.
- Simultaneous events:
  - Done and allDone both high in SHIP: go to RET only; allDone is re-sampled in RET.
  - allDone on the same cycle the watchdog expires: completion wins; ack is issued.
- Colour sampling: frame_grb is stable from ARB through GAP; changes on req_grb after capture are ignored.
- Reset asserted mid-frame: shipGRB drops immediately (asynchronously) and all pending requests are discarded.
- Width rules:
  - frames and the counters wrap modularly.
  - Counter widths are clog2 of their parameter plus 1.

Decomposition:
- Shared package led_pkg:
  - state encoding localparams S_IDLE..S_GAP;
  - colour constants GREEN, BLUE, RED, YELLOW, BLANK, all 12-bit;
  - requester index constants REQ_GO, REQ_AUTO, REQ_GAME.
- One sub-module, rr_arbiter3: inputs pending[2:0] and rr[1:0]; outputs one-hot gnt[2:0] and idx[1:0]; purely combinational.
- The FSM, counters and capture logic stay in the top level.

Test Plan:
- Single request: req[0] rises with req_grb[11:0]=0x800, shipper answers Done after 10 cycles and allDone after 5 more -> shipGRB high on the 3rd edge, frame_grb=0x800, ack[0] one pulse, frames=1, grant=0 after GAP_CYC (run with GAP_CYC=8).
- Round-robin: req[0], req[1] and req[2] rise in the same cycle with colours 0x800, 0x008, 0x080 -> grants in order 0, 1, 2, frame_grb following, frames=3. Then req[2] and req[0] together -> grant 0 first, because rr=0 after serving 2.
- Overwrite: req[1] edges twice during another frame (0x008, then 0x880) -> exactly one frame for requester 1, with frame_grb=0x880.
- Watchdog (WDOG_CYC=50): Done never asserts -> shipGRB falls at cycle 50, wdog_err=1, no ack, frames unchanged, next pending request is still served.
- Reset mid-SHIP: drive reset=0 asynchronously -> shipGRB=0 with no clock edge needed, all outputs at reset values, pending cleared, no frame after release.
- Gap enforcement: allDone, then a new req one cycle later -> shipGRB does not rise before GAP_CYC+2 cycles after allDone.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED frame scheduler: state codes, stock colours, requester indices.
package led_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_SHIP = 3'd2;
    localparam logic [2:0] S_RET  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        ARB  = S_ARB,
        SHIP = S_SHIP,
        RET  = S_RET,
        GAP  = S_GAP
    } state_t;

    // 12-bit GRB: green [11:8], red [7:4], blue [3:0]
    localparam logic [11:0] GREEN  = 12'hF00;
    localparam logic [11:0] RED    = 12'h0F0;
    localparam logic [11:0] BLUE   = 12'h00F;
    localparam logic [11:0] YELLOW = 12'hFF0;
    localparam logic [11:0] BLANK  = 12'h000;

    localparam int REQ_GO   = 0;
    localparam int REQ_AUTO = 1;
    localparam int REQ_GAME = 2;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin pick: first pending index at or after rr, wrapping modulo 3.
module rr_arbiter3
    import led_pkg::*;
(
    input  logic [2:0] pending,
    input  logic [1:0] rr,
    output logic [2:0] gnt,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        // NOTE: every output and temporary gets a default before any branch, so no latch is inferred.
        gnt  = '0;
        idx  = '0;
        cand = (rr > 2'd2) ? 2'd0 : rr;
        for (int k = 0; k < 3; k++) begin
            if (gnt == 3'b000 && pending[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/led_frame_scheduler.sv
// Shares the GRB serial shipper between three frame requesters with round-robin grant,
// inter-frame gap enforcement and a stall watchdog.
module led_frame_scheduler
    import led_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int GAP_CYC  = 1000,
    parameter int WDOG_CYC = 2000000,
    parameter int CW       = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*CW-1:0]   req_grb,
    input  logic                 Done,
    input  logic                 allDone,
    output logic                 shipGRB,
    output logic [CW-1:0]        frame_grb,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic                 wdog_err,
    output logic [15:0]          frames
);

    localparam int GW = $clog2(GAP_CYC) + 1;
    localparam int WW = $clog2(WDOG_CYC) + 1;

    state_t          state, state_nxt;
    logic [NREQ-1:0] req_q, pending, req_edge, arb_gnt;
    logic [1:0]      rr, arb_idx;
    logic [CW-1:0]   col [NREQ];
    logic [GW-1:0]   gap_cnt;
    logic [WW-1:0]   wdog_cnt;
    logic            gap_done, wdog_expire, complete, abort;

    assign req_edge    = req & ~req_q;
    assign gap_done    = (gap_cnt == GW'(GAP_CYC - 1));
    assign wdog_expire = (wdog_cnt >= WW'(WDOG_CYC - 1));
    assign complete    = (state == RET) && allDone;
    assign abort       = wdog_expire && (((state == SHIP) && !Done) || ((state == RET) && !allDone));
    assign shipGRB     = (state == SHIP);
    assign busy        = (state != IDLE);

    rr_arbiter3 u_arb (
        .pending (pending),
        .rr      (rr),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|pending) state_nxt = ARB;
            ARB:     state_nxt = SHIP;
            SHIP:    if (Done) state_nxt = RET;
                     else if (wdog_expire) state_nxt = GAP;
            RET:     if (allDone || wdog_expire) state_nxt = GAP;
            GAP:     if (gap_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the colour store has no reset; a slot is read only after its own capture edge wrote it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (req_edge[i]) col[i] <= req_grb[i*CW +: CW];
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_q     <= '0;
            pending   <= '0;
            rr        <= '0;
            frame_grb <= BLANK;
            grant     <= '0;
            ack       <= '0;
            wdog_err  <= 1'b0;
            frames    <= '0;
            gap_cnt   <= '0;
            wdog_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            req_q   <= req;
            ack     <= '0;
            // a fresh edge on the requester being granted keeps it owed one more frame
            pending <= (pending & ~((state == ARB) ? arb_gnt : '0)) | req_edge;

            if (state == ARB) begin
                grant     <= arb_gnt;
                frame_grb <= col[arb_idx];
                rr        <= rr_next(arb_idx);
            end

            wdog_cnt <= (state == SHIP || state == RET) ? wdog_cnt + 1'b1 : '0;
            gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;

            if (complete) begin
                ack    <= grant;
                frames <= frames + 16'd1;
            end else if (abort) begin
                wdog_err <= 1'b1;
            end

            if (state == GAP && gap_done) grant <= '0;
        end
    end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Self-checking bench: frame-level reference model (pending set, colours, rotating pointer)
// with directed scenarios plus randomized request/shipper timing.
module tb_led_frame_scheduler;
    import led_pkg::*;

    localparam int GAP_CYC  = 8;
    localparam int WDOG_CYC = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0;
    logic [35:0] req_grb = '0;
    logic        Done = 1'b0;
    logic        allDone = 1'b0;
    logic        shipGRB;
    logic [11:0] frame_grb;
    logic [2:0]  grant, ack;
    logic        busy, wdog_err;
    logic [15:0] frames;

    led_frame_scheduler #(
        .NREQ(3), .GAP_CYC(GAP_CYC), .WDOG_CYC(WDOG_CYC), .CW(12)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_grb(req_grb),
        .Done(Done), .allDone(allDone), .shipGRB(shipGRB), .frame_grb(frame_grb),
        .grant(grant), .ack(ack), .busy(busy), .wdog_err(wdog_err), .frames(frames)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: what is owed, with which colour, and who is next in the rotation
    bit          m_pend [3];
    logic [11:0] m_col  [3];
    int          m_rr;
    logic [15:0] m_frames;
    int          cur;
    logic [11:0] cur_col;
    int          ship_cyc, e_cyc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset   = 1'b0;
        req     = '0;
        Done    = 1'b0;
        allDone = 1'b0;
        #1;
        check("rst_ship", shipGRB, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        check("rst_frame_grb", frame_grb, 0);
        check("rst_wdog", wdog_err, 0);
        check("rst_frames", frames, 0);
        for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
        m_rr     = 0;
        m_frames = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] mask, input logic [11:0] c0, input logic [11:0] c1,
                         input logic [11:0] c2);
        logic [11:0] cs [3];
        cs[0] = c0; cs[1] = c1; cs[2] = c2;
        for (int i = 0; i < 3; i++)
            if (mask[i]) begin
                req_grb[i*12 +: 12] = cs[i];
                m_pend[i] = 1'b1;
                m_col[i]  = cs[i];
            end
        req = req | mask;
        @(negedge clk);
        req = req & ~mask;
        req_grb = 36'({$urandom(), $urandom()});
        @(negedge clk);
    endtask

    task automatic start_frame();
        int n = 0;
        while (shipGRB !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ship_start", shipGRB, 1);
        ship_cyc = cyc;
        cur = -1;
        for (int k = 0; k < 3; k++)
            if (cur < 0 && m_pend[(m_rr + k) % 3]) cur = (m_rr + k) % 3;
        if (cur < 0) cur = 0;
        cur_col = m_col[cur];
        check("grant", grant, 32'd1 << cur);
        check("frame_grb", frame_grb, cur_col);
        m_pend[cur] = 1'b0;
        m_rr = (cur + 1) % 3;
    endtask

    task automatic finish_frame(input int done_dly, input int all_dly, input bit both);
        repeat (done_dly) @(negedge clk);
        Done = 1'b1;
        if (both) allDone = 1'b1;
        @(negedge clk);
        Done    = 1'b0;
        allDone = 1'b0;
        check("ret_ship_low", shipGRB, 0);
        if (both) check("both_no_ack", ack, 0);
        repeat (all_dly) @(negedge clk);
        allDone = 1'b1;
        @(negedge clk);
        allDone = 1'b0;
        e_cyc = cyc;
        m_frames = m_frames + 16'd1;
        check("ack", ack, 32'd1 << cur);
        check("frames", frames, m_frames);
        check("frame_grb_hold", frame_grb, cur_col);
        @(negedge clk);
        check("ack_pulse", ack, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int t_req;
        bit seen;
        logic [2:0] mask;

        // single request: latency, completion, gap release
        do_reset();
        t_req = cyc;
        issue(3'b001, 12'h800, BLANK, BLANK);
        start_frame();
        check("latency", ship_cyc - t_req, 3);
        finish_frame(10, 5, 1'b0);
        repeat (GAP_CYC - 2) @(negedge clk);
        check("gap_grant_held", grant, 3'b001);
        check("gap_busy", busy, 1);
        @(negedge clk);
        check("gap_grant_clear", grant, 0);
        check("idle_busy", busy, 0);

        // round robin from a fresh pointer
        do_reset();
        issue(3'b111, 12'h800, 12'h008, 12'h080);
        for (int f = 0; f < 3; f++) begin
            start_frame();
            finish_frame($urandom_range(1, 8), $urandom_range(1, 8), 1'b0);
        end
        check("rr_frames", frames, 3);
        issue(3'b101, GREEN, BLANK, RED);
        start_frame();
        check("rr_wrap_grant0", grant, 3'b001);
        finish_frame(3, 3, 1'b0);
        start_frame();
        finish_frame(3, 3, 1'b0);

        // overwrite: two edges on requester 1 during another frame
        issue(3'b001, GREEN, BLANK, BLANK);
        start_frame();
        issue(3'b010, BLANK, 12'h008, BLANK);
        issue(3'b010, BLANK, 12'h880, BLANK);
        finish_frame(4, 4, 1'b0);
        start_frame();
        check("overwrite_col", frame_grb, 12'h880);
        finish_frame(4, 4, 1'b0);
        repeat (GAP_CYC + 10) @(negedge clk);
        check("no_extra_frame", busy, 0);

        // allDone in the very cycle the watchdog expires: completion wins
        issue(3'b100, BLANK, BLANK, YELLOW);
        start_frame();
        finish_frame(10, WDOG_CYC - 12, 1'b0);
        check("late_done_no_wdog", wdog_err, 0);
        repeat (GAP_CYC + 2) @(negedge clk);

        // watchdog abort, then the owed request is still served
        issue(3'b001, RED, BLANK, BLANK);
        start_frame();
        issue(3'b100, BLANK, BLANK, BLUE);
        begin
            int n = 0;
            while (shipGRB === 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("wdog_len", cyc - ship_cyc, WDOG_CYC);
        check("wdog_err", wdog_err, 1);
        check("wdog_no_ack", ack, 0);
        check("wdog_frames", frames, m_frames);
        start_frame();
        finish_frame(5, 5, 1'b0);

        // gap enforcement: new request one cycle after allDone
        issue(3'b010, BLANK, GREEN, BLANK);
        start_frame();
        check("gap_min", ship_cyc - e_cyc, GAP_CYC + 2);
        finish_frame(2, 2, 1'b1);

        // randomized traffic and shipper timing
        for (int it = 0; it < 30; it++) begin
            if (!(m_pend[0] || m_pend[1] || m_pend[2])) begin
                mask = 3'($urandom_range(1, 7));
                issue(mask, 12'($urandom), 12'($urandom), 12'($urandom));
            end
            start_frame();
            repeat ($urandom_range(0, 2)) begin
                mask = 3'($urandom_range(1, 7));
                issue(mask, 12'($urandom), 12'($urandom), 12'($urandom));
            end
            finish_frame($urandom_range(0, 12), $urandom_range(0, 12), ($urandom_range(0, 3) == 0));
        end
        check("wdog_sticky", wdog_err, 1);

        // asynchronous reset in the middle of a frame discards everything owed
        if (!(m_pend[0] || m_pend[1] || m_pend[2])) issue(3'b001, GREEN, BLANK, BLANK);
        start_frame();
        issue(3'b110, BLANK, RED, BLUE);
        repeat (3) @(negedge clk);
        do_reset();
        seen = 1'b0;
        repeat (GAP_CYC + 20) begin
            @(negedge clk);
            if (shipGRB === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        check("no_frame_after_reset", seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
